// File: rtl/typing_score_engine.sv
// rtl/typing_score_engine.sv - typing-game scorer: key buffer, word commit, game FSM, bit-serial WPM/accuracy
// Optional macro TYPE_AUTOCOMMIT_EN: commit as soon as the word is fully and correctly typed.
module typing_score_engine #(
   parameter  int MAX_LEN   = 25,
   parameter  int CHAR_W    = 5,
   parameter  int TICK_HZ   = 100,
   parameter  int TIMER_MAX = 18000,
   parameter  int STAT_W    = 24,
   localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tick,
   input  logic                       start,
   input  logic                       mode,
   input  logic [6:0]                 limit,
   input  logic                       key_valid,
   input  logic [1:0]                 key_kind,
   input  logic [CHAR_W-1:0]          key_code,
   input  logic [MAX_LEN*CHAR_W-1:0]  word,
   input  logic [LEN_W-1:0]           word_len,
   output logic                       next_word,
   output logic [MAX_LEN*CHAR_W-1:0]  typed,
   output logic [LEN_W-1:0]           cursor,
   output logic [LEN_W-1:0]           correct,
   output logic [6:0]                 words_done,
   output logic [14:0]                timer,
   output logic                       finish,
   output logic [9:0]                 wpm,
   output logic [6:0]                 acc,
   output logic                       stats_busy
);
   localparam int REM_W = $clog2(128 * TICK_HZ + 1);
   localparam int CNT_W = $clog2(2 * STAT_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
   state_t state, state_nxt;

   logic                      mode_r;
   logic [6:0]                limit_r;
   logic [REM_W-1:0]          remain;
   logic [STAT_W-1:0]         tot_typed, tot_ok, tot_typed_nxt, tot_ok_nxt;
   logic [MAX_LEN*CHAR_W-1:0] typed_nxt;
   logic [LEN_W-1:0]          cursor_nxt, correct_now;
   logic                      match_run, fin_hit, enter_fin, run_active, commit, auto_hit, stat_req;

   logic [CNT_W-1:0]          cnt;
   logic [STAT_W-1:0]         rem, quo, den, wpm_num, wpm_den, rem_new, q_new, r_sub;
   logic [STAT_W:0]           r_sh;
   logic                      q_bit;
   logic [6:0]                acc_q;

   // Leading-match count; the first mismatch ends the run.
   always_comb begin
      correct_now = '0;
      match_run   = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (match_run && (LEN_W'(i) < cursor) && (LEN_W'(i) < word_len) &&
             (typed[i*CHAR_W +: CHAR_W] == word[i*CHAR_W +: CHAR_W]))
            correct_now = correct_now + LEN_W'(1);
         else
            match_run = 1'b0;
      end
   end

`ifdef TYPE_AUTOCOMMIT_EN
   assign auto_hit = (cursor != '0) && (cursor == word_len) && (correct_now == word_len);
`else
   assign auto_hit = 1'b0;
`endif

   assign fin_hit = (timer == 15'(TIMER_MAX)) || (!mode_r && (remain == '0)) ||
                    (mode_r && (words_done == limit_r));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      enter_fin  = 1'b0;
      run_active = 1'b0;
      finish     = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (start) state_nxt = S_RUN;
            else if (fin_hit) begin
               state_nxt = S_FIN;
               enter_fin = 1'b1;
            end else run_active = 1'b1;
         end
         S_FIN: begin
            finish = 1'b1;
            if (start) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      typed_nxt  = typed;
      cursor_nxt = cursor;
      commit     = 1'b0;
      if (run_active) begin
         if (auto_hit) commit = 1'b1;
         else if (key_valid) begin
            case (key_kind)
               2'b00: if (cursor < LEN_W'(MAX_LEN)) begin
                  for (int i = 0; i < MAX_LEN; i++)
                     if (LEN_W'(i) == cursor) typed_nxt[i*CHAR_W +: CHAR_W] = key_code;
                  cursor_nxt = cursor + LEN_W'(1);
               end
               2'b01: if (cursor != '0) begin
                  for (int i = 0; i < MAX_LEN; i++)
                     if (LEN_W'(i) == cursor - LEN_W'(1)) typed_nxt[i*CHAR_W +: CHAR_W] = '0;
                  cursor_nxt = cursor - LEN_W'(1);
               end
               2'b10: commit = (cursor != '0);
               default: ;
            endcase
         end
         if (commit) begin
            typed_nxt  = '0;
            cursor_nxt = '0;
         end
      end
   end

   // FIN entry folds the partial word into the final totals.
   assign tot_typed_nxt = tot_typed + STAT_W'(cursor);
   assign tot_ok_nxt    = tot_ok + STAT_W'(correct_now);
   assign stat_req      = commit | enter_fin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         typed <= '0; cursor <= '0; correct <= '0; words_done <= '0; timer <= '0;
         remain <= '0; mode_r <= 1'b0; limit_r <= '0; tot_typed <= '0; tot_ok <= '0;
         next_word <= 1'b0;
      end else if (start) begin
         typed <= '0; cursor <= '0; correct <= '0; words_done <= '0; timer <= '0;
         remain <= REM_W'(limit) * REM_W'(TICK_HZ); mode_r <= mode; limit_r <= limit;
         tot_typed <= '0; tot_ok <= '0; next_word <= 1'b0;
      end else begin
         next_word <= commit;
         if (state == S_RUN) correct <= correct_now;
         if (run_active) begin
            typed  <= typed_nxt;
            cursor <= cursor_nxt;
            if (tick) begin
               if (timer != 15'(TIMER_MAX)) timer <= timer + 15'd1;
               if (remain != '0) remain <= remain - REM_W'(1);
            end
         end
         if (stat_req) begin
            tot_typed <= tot_typed_nxt;
            tot_ok    <= tot_ok_nxt;
         end
         if (commit) words_done <= words_done + 7'd1;
      end
   end

   // Restoring division step: one quotient bit per clock.
   assign r_sh    = {rem, quo[STAT_W-1]};
   assign q_bit   = (r_sh >= {1'b0, den});
   assign r_sub   = r_sh[STAT_W-1:0] - den;
   assign rem_new = q_bit ? r_sub : r_sh[STAT_W-1:0];
   assign q_new   = {quo[STAT_W-2:0], q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stats_busy <= 1'b0; cnt <= '0; rem <= '0; quo <= '0; den <= '0;
         wpm_num <= '0; wpm_den <= '0; acc_q <= '0; acc <= '0; wpm <= '0;
      end else if (start) begin
         stats_busy <= 1'b0; cnt <= '0; rem <= '0; quo <= '0; den <= '0;
         wpm_num <= '0; wpm_den <= '0; acc_q <= '0; acc <= '0; wpm <= '0;
      end else if (stat_req) begin
         stats_busy <= 1'b1;
         cnt        <= '0;
         rem        <= '0;
         quo        <= tot_ok_nxt * STAT_W'(100);
         den        <= tot_typed_nxt;
         wpm_num    <= tot_ok_nxt * STAT_W'(TICK_HZ * 12);
         wpm_den    <= STAT_W'(timer);
      end else if (stats_busy) begin
         cnt <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(2 * STAT_W)) begin
            stats_busy <= 1'b0;
            acc        <= acc_q;
            wpm        <= (den == '0) ? 10'd0 : ((quo > STAT_W'(999)) ? 10'd999 : quo[9:0]);
         end else if (cnt == CNT_W'(STAT_W - 1)) begin
            acc_q <= (den == '0) ? 7'd0 : ((q_new > STAT_W'(100)) ? 7'd100 : q_new[6:0]);
            rem   <= '0;
            quo   <= wpm_num;
            den   <= wpm_den;
         end else begin
            rem <= rem_new;
            quo <= q_new;
         end
      end
   end
endmodule
